// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_pkg
// Description : Shared definitions for the display scan arbiter: arbitration
//               state encoding, hex glyph table (active-high, [6]=a .. [0]=g)
//               and the all-anodes-off pattern.
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    typedef enum logic [1:0] {
        S_DEFAULT = 2'd0,
        S_HOLD    = 2'd1,
        S_OPEN    = 2'd2
    } state_t;

    localparam logic [3:0] ANODES_OFF = 4'b1111;

    // Entry n is the glyph for hex digit n; listed from F down to 0.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h47, 7'h4F, 7'h3D, 7'h4E,   // F E d C
        7'h1F, 7'h77, 7'h7B, 7'h7F,   // b A 9 8
        7'h70, 7'h5F, 7'h5B, 7'h33,   // 7 6 5 4
        7'h79, 7'h6D, 7'h30, 7'h7E    // 3 2 1 0
    };

    function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
        return HEX_GLYPH[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/disp_scan_arbiter_hex7.sv
`default_nettype none
// ============================================================================
// Module      : hex7
// Description : Combinational hex-nibble to 7-segment glyph decoder.
// Ports       : nibble - 4-bit hex value
//               glyph  - active-high segments, [6]=a .. [0]=g
// Revision    : 1.0 - initial release
// ============================================================================
module hex7
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = hex_glyph(nibble);

endmodule
`default_nettype wire

// File: rtl/disp_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : disp_scan_arbiter
// Description : Scans a 4-digit active-low 7-segment display and shares it
//               between NUM_SRC 16-bit hex sources. Grants are round-robin
//               with a minimum hold of HOLD_TICKS scan ticks; the shown value
//               is latched once per 4-tick frame so digits never tear.
// Ports       : display_clk  - scan tick (one digit slot per tick)
//               reset        - asynchronous, active-high
//               src_data     - source i at [16i+15:16i]
//               src_req      - level request per source
//               blank        - forces all anodes off
//               src_grant    - one-hot owner, zero when no owner
//               display_an   - anodes, active-low, bit k = digit k
//               display_atog - segments, active-low, [6]=a .. [0]=g
//               display_dp   - decimal point, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module disp_scan_arbiter
    import disp_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int HOLD_TICKS = 1000
) (
    input  logic                  display_clk,
    input  logic                  reset,
    input  logic [16*NUM_SRC-1:0] src_data,
    input  logic [NUM_SRC-1:0]    src_req,
    input  logic                  blank,
    output logic [NUM_SRC-1:0]    src_grant,
    output logic [3:0]            display_an,
    output logic [6:0]            display_atog,
    output logic                  display_dp
);

    localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (int'(idx) >= NUM_SRC - 1)
            return '0;
        return idx + IDX_W'(1);
    endfunction

    // First requester scanning start, start+1, ... modulo NUM_SRC.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_SRC-1:0] req,
        input logic [IDX_W-1:0]   start
    );
        logic [IDX_W-1:0] win;
        logic             found;
        int               idx;
        win   = start;
        found = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = (int'(start) + i) % NUM_SRC;
            if (!found && req[idx]) begin
                win   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // ------------------------------------------------------------------
    // Source words unpacked for indexed selection
    // ------------------------------------------------------------------
    logic [15:0] src_word [NUM_SRC];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign src_word[gi] = src_data[16*gi +: 16];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state;
    logic [1:0]          scan_cnt;
    logic [15:0]         frame_buf;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    owner;
    logic [HOLD_W-1:0]   hold_cnt;

    // ------------------------------------------------------------------
    // Next-state / arbitration decision
    // ------------------------------------------------------------------
    logic                boundary;
    logic [NUM_SRC-1:0]  owner_onehot;
    logic [NUM_SRC-1:0]  others_req;
    state_t              nxt_state;
    logic [IDX_W-1:0]    nxt_owner;
    logic [IDX_W-1:0]    winner;
    logic                take;
    logic [IDX_W-1:0]    show_idx;

    assign boundary     = (scan_cnt == 2'd3);
    assign owner_onehot = NUM_SRC'(1) << owner;
    assign others_req   = src_req & ~owner_onehot;

    always_comb begin
        nxt_state = state;
        nxt_owner = owner;
        winner    = '0;
        take      = 1'b0;
        case (state)
            S_DEFAULT: begin
                if (boundary && (|src_req)) begin
                    winner    = rr_pick(src_req, rr_ptr);
                    take      = 1'b1;
                    nxt_state = S_HOLD;
                end
            end
            S_HOLD: begin
                // Owner's request is ignored here: the hold is guaranteed.
                if (hold_cnt == HOLD_LAST)
                    nxt_state = S_OPEN;
            end
            S_OPEN: begin
                if (boundary) begin
                    if (|others_req) begin
                        winner    = rr_pick(others_req, next_idx(owner));
                        take      = 1'b1;
                        nxt_state = S_HOLD;
                    end else if (!src_req[owner]) begin
                        nxt_state = S_DEFAULT;
                    end
                end
            end
            default: nxt_state = S_DEFAULT;
        endcase
        if (take)
            nxt_owner = winner;
        // Frame buffer follows the owner chosen on this very edge.
        show_idx = (nxt_state == S_DEFAULT) ? '0 : nxt_owner;
    end

    // ------------------------------------------------------------------
    // Single sequential block: scan, FSM, frame latch, registered grant
    // ------------------------------------------------------------------
    always_ff @(posedge display_clk or posedge reset) begin
        if (reset) begin
            scan_cnt  <= 2'd0;
            frame_buf <= 16'h0000;
            state     <= S_DEFAULT;
            rr_ptr    <= '0;
            owner     <= '0;
            hold_cnt  <= '0;
            src_grant <= '0;
        end else begin
            scan_cnt <= scan_cnt + 2'd1;
            state    <= nxt_state;
            owner    <= nxt_owner;
            if (take) begin
                hold_cnt <= '0;
                rr_ptr   <= next_idx(winner);
            end else if (state == S_HOLD && hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            if (boundary)
                frame_buf <= src_word[show_idx];
            src_grant <= (nxt_state == S_DEFAULT) ? '0 : (NUM_SRC'(1) << nxt_owner);
        end
    end

    // ------------------------------------------------------------------
    // Display outputs (from registers only, except blank)
    // ------------------------------------------------------------------
    logic [3:0] nibble;
    logic [6:0] glyph;

    always_comb begin
        case (scan_cnt)
            2'd0:    nibble = frame_buf[3:0];
            2'd1:    nibble = frame_buf[7:4];
            2'd2:    nibble = frame_buf[11:8];
            default: nibble = frame_buf[15:12];
        endcase
    end

    hex7 u_hex7 (
        .nibble (nibble),
        .glyph  (glyph)
    );

    assign display_an   = blank ? ANODES_OFF : ~(4'b0001 << scan_cnt);
    assign display_atog = ~glyph;
    // Lit on the last digit whenever a non-default source owns the display.
    assign display_dp   = ~((scan_cnt == 2'd3) && (state != S_DEFAULT));

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp_scan_arbiter
// Description : Self-checking bench for disp_scan_arbiter (NUM_SRC=3,
//               HOLD_TICKS=8). A reference model predicts every tick's
//               outputs into a scoreboard queue; the DUT response is popped
//               and compared after each edge. Directed checks cover reset,
//               grant timing, hold length, rotation order, blank and async
//               reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_scan_arbiter;

    localparam int N    = 3;
    localparam int HOLD = 8;

    logic            display_clk;
    logic            reset;
    logic [16*N-1:0] src_data;
    logic [N-1:0]    src_req;
    logic            blank;
    logic [N-1:0]    src_grant;
    logic [3:0]      display_an;
    logic [6:0]      display_atog;
    logic            display_dp;

    logic [15:0] word [N];
    assign src_data = {word[2], word[1], word[0]};

    disp_scan_arbiter #(
        .NUM_SRC    (N),
        .HOLD_TICKS (HOLD)
    ) dut (
        .display_clk  (display_clk),
        .reset        (reset),
        .src_data     (src_data),
        .src_req      (src_req),
        .blank        (blank),
        .src_grant    (src_grant),
        .display_an   (display_an),
        .display_atog (display_atog),
        .display_dp   (display_dp)
    );

    initial display_clk = 1'b0;
    always #5 display_clk = ~display_clk;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    localparam int ST_DEF = 0, ST_HOLD = 1, ST_OPEN = 2;

    int          m_scan, m_state, m_owner, m_rr, m_hold;
    logic [15:0] m_fb;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] atog;
        logic       dp;
        logic [2:0] grant;
    } exp_t;

    exp_t sb [$];

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    function automatic int pick(input logic [2:0] r, input int p);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return p;
    endfunction

    task automatic model_reset();
        m_scan = 0; m_state = ST_DEF; m_owner = 0; m_rr = 0; m_hold = 0; m_fb = 16'h0;
    endtask

    task automatic model_grant(input int w);
        m_owner = w; m_hold = 0; m_state = ST_HOLD; m_rr = (w + 1) % N;
    endtask

    task automatic model_step();
        logic       bnd;
        logic [2:0] oth;
        int         prev;
        bnd  = (m_scan == 3);
        prev = m_state;
        if (prev == ST_DEF) begin
            if (bnd && src_req != 3'b000) model_grant(pick(src_req, m_rr));
        end else if (prev == ST_HOLD) begin
            if (m_hold == HOLD - 1) m_state = ST_OPEN;
            else m_hold = m_hold + 1;
        end else begin
            if (bnd) begin
                oth = src_req & ~(3'b001 << m_owner);
                if (oth != 3'b000) model_grant(pick(oth, (m_owner + 1) % N));
                else if (!src_req[m_owner]) m_state = ST_DEF;
            end
        end
        if (bnd) m_fb = (m_state == ST_DEF) ? word[0] : word[m_owner];
        m_scan = (m_scan + 1) % 4;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.an    = blank ? 4'b1111 : ~(4'b0001 << m_scan);
        e.atog  = ~seg(m_fb[4*m_scan +: 4]);
        e.dp    = !(m_scan == 3 && m_state != ST_DEF);
        e.grant = (m_state == ST_DEF) ? 3'b000 : (3'b001 << m_owner);
        return e;
    endfunction

    // One clock edge: predict, then compare the DUT response.
    task automatic tick();
        exp_t e;
        model_step();
        sb.push_back(model_out());
        @(posedge display_clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("an",    {28'd0, display_an},   {28'd0, e.an});
            check("atog",  {25'd0, display_atog}, {25'd0, e.atog});
            check("dp",    {31'd0, display_dp},   {31'd0, e.dp});
            check("grant", {29'd0, src_grant},    {29'd0, e.grant});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, {29'd0, src_grant},    32'd0);
        check({tag, "_an"},    {28'd0, display_an},   32'h0000_000E);
        check({tag, "_atog"},  {25'd0, display_atog}, 32'h0000_0001);
        check({tag, "_dp"},    {31'd0, display_dp},   32'd1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int   held;
    int   chg_t [$];
    logic [2:0] chg_g [$];
    logic [2:0] last_g;

    initial begin
        reset   = 1'b1;
        blank   = 1'b0;
        src_req = 3'b000;
        word[0] = 16'h1234;
        word[1] = 16'hA5C0;
        word[2] = 16'h0000;
        model_reset();

        // 1. Reset and default scan
        #12;
        check_reset_outputs("rst");
        reset = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        // 2/3. Single request on source 2, raised at scan_cnt==1, dropped
        //      one tick after the grant.
        for (int i = 0; i < 4 && m_scan != 1; i++) tick();
        check("align_scan1", m_scan, 32'd1);
        word[2] = 16'hBEEF;
        src_req = 3'b100;
        held    = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (i == 2) check("grant_at_boundary", {29'd0, src_grant}, 32'd4);
            if (i == 3) src_req = 3'b000;
            if (src_grant == 3'b100) held++;
        end
        check("hold_len", held, 32'd12);
        check("released", {29'd0, src_grant}, 32'd0);

        // 4. Fairness under constant full request
        src_req = 3'b111;
        last_g  = 3'b000;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (src_grant != last_g && src_grant != 3'b000) begin
                chg_t.push_back(i);
                chg_g.push_back(src_grant);
            end
            last_g = src_grant;
        end
        check("n_grants", chg_g.size() >= 4, 32'd1);
        if (chg_g.size() >= 4) begin
            check("rot0", {29'd0, chg_g[0]}, 32'd1);
            check("rot1", {29'd0, chg_g[1]}, 32'd2);
            check("rot2", {29'd0, chg_g[2]}, 32'd4);
            check("rot3", {29'd0, chg_g[3]}, 32'd1);
            check("rot_len", chg_t[2] - chg_t[1], 32'd12);
        end

        // 5. Blank keeps arbitration running
        blank = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("blank_an", {28'd0, display_an}, 32'h0000_000F);
        check("blank_grant_on", src_grant != 3'b000, 32'd1);
        blank = 1'b0;
        tick();

        // Asynchronous reset pulse between edges
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_rst");
        #1 reset = 1'b0;
        model_reset();
        sb.delete();
        src_req = 3'b000;
        for (int i = 0; i < 8; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
